vita49_pack_arb: RTL
====================

Name: vita49_pack_arb

Overview:
- Packet-granular round-robin arbiter that shares one vita49_pack datapath among NUM_CH independent 32-bit AXI-Stream sample sources.
- Sits between the channel sources and the packer's S_AXIS port.
- Holds a grant for one burst: up to TLAST, or up to a programmed word limit.
- Presents the granted channel's index and derived stream ID, so the packer's streamID tracks the active source.

Parameters:
- NUM_CH, 4, number of requesting streams (2..16).
- CNT_W, 16, width of burst word counter and burst_len.

Ports:
- AXIS_ACLK  in  1  stream clock.
- AXIS_ARESETN  in  1  reset, asynchronous, active-low.
- enable  in  1  arbitration enable; low = finish current burst, then idle.
- burst_len  in  CNT_W  max words per grant; 0 = end burst on TLAST only.
- stream_id_base  in  32  stream ID of channel 0.
- S_AXIS_TVALID  in  NUM_CH  per-channel valid.
- S_AXIS_TDATA  in  32*NUM_CH  per-channel data; channel k at bits [32k+31:32k].
- S_AXIS_TLAST  in  NUM_CH  per-channel end of packet.
- S_AXIS_TREADY  out  NUM_CH  per-channel ready.
- M_AXIS_TVALID  out  1  to packer.
- M_AXIS_TDATA  out  32  to packer.
- M_AXIS_TLAST  out  1  burst end marker.
- M_AXIS_TREADY  in  1  from packer.
- grant_valid  out  1  a grant is active.
- grant_ch  out  clog2(NUM_CH)  granted channel index.
- stream_id  out  32  stream_id_base + grant_ch, registered at grant.

Behaviour:
- Reset values (async assert, sync deassert by caller):
  - state=IDLE, grant_valid=0, grant_ch=0, stream_id=0.
  - Word count=0, last_grant=NUM_CH-1, so channel 0 wins first.
  - All S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0.
- States: IDLE, ACTIVE.
- IDLE:
  - All readies 0; M_AXIS_TVALID=0.
  - If enable=1 and any S_AXIS_TVALID=1: select the first requester scanning last_grant+1, last_grant+2, ... modulo NUM_CH.
  - Registered on that edge: grant_ch, grant_valid=1, stream_id=stream_id_base+grant_ch (32-bit wrap), burst_len latched into lim, count=0.
  - Then go to ACTIVE. One bubble cycle between request and first transfer.
- ACTIVE, combinational mux on grant_ch g:
  - M_AXIS_TVALID=S_AXIS_TVALID[g]; M_AXIS_TDATA=data[g].
  - S_AXIS_TREADY[g]=M_AXIS_TREADY; all other readies 0.
  - M_AXIS_TLAST=S_AXIS_TLAST[g] OR (lim!=0 AND count==lim-1).
- Handshake = M_AXIS_TVALID & M_AXIS_TREADY.
  - Each handshake increments count.
  - A handshake with M_AXIS_TLAST=1: last_grant=g, count=0, grant_valid=0, go to IDLE.
- Timing: zero-latency pass-through while ACTIVE; no data registers.
- Boundary conditions:
  - enable falling mid-burst: burst completes normally; no new grant while low.
  - burst_len changed mid-burst: no effect until next grant (latched lim).
  - burst_len=1: every word ends the burst; each requester gets one word in turn.
  - Source TLAST before lim: burst ends at TLAST; count resets.
  - count reaching lim without TLAST: arbiter asserts TLAST and releases; the source's packet continues at its next grant.
  - Granted channel drops TVALID mid-burst: grant held; no other channel is served.
  - Single requester: re-granted every burst, one idle cycle between bursts.
  - Backpressure (M_AXIS_TREADY=0): all state held; TDATA/TLAST stable as driven by the source.
  - Reset asserted mid-burst: outputs go to reset values immediately; partial burst abandoned.

Decomposition:
- Package vita49_pkg holds:
  - state enum {IDLE, ACTIVE};
  - default NUM_CH, CNT_W;
  - function clog2.
- Sub-module rr_arbiter: combinational rotate-priority select of req[NUM_CH-1:0] from last_grant; outputs gnt_idx and gnt_any. Reusable by future multi-source blocks.

Test Plan:
- Reset, then ch0/ch2 TVALID=1, burst_len=0, each 3-word packet with TLAST on word 3:
  - grant order ch0, ch2, ch0.
  - stream_id = base+0, base+2.
  - 3 words per grant; one bubble between grants.
- All 4 channels streaming, burst_len=4, no TLAST:
  - grants rotate 0,1,2,3,0.
  - M_AXIS_TLAST on every 4th handshake.
  - other channels' TREADY=0 throughout.
- burst_len=8, ch1 sends TLAST on word 5:
  - burst ends after 5 words; count resets; next grant goes to the next requester.
- M_AXIS_TREADY toggled randomly 50%, ch3 sends 16 words:
  - output word sequence identical to input; no drops or duplicates; TLAST position preserved.
- enable dropped on word 2 of a 6-word burst:
  - burst completes 6 words; grant_valid=0 afterwards.
  - no grant while enable=0 despite pending TVALID.
- AXIS_ARESETN asserted mid-burst:
  - all TREADY, M_AXIS_TVALID and grant_valid=0 in the same cycle.
  - after release, first grant goes to lowest pending channel (starting ch0).

Source files
------------

// File: rtl/vita49_pack_arb_pkg.sv
// Shared types and defaults for the vita49_pack channel arbiter slice.
package vita49_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  // Minimum 1 so a 1-channel build still yields a legal vector width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/vita49_pack_arb_rr_arbiter.sv
// Combinational rotate-priority selector: first requester after last_grant wins.
module rr_arbiter
  import vita49_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);

  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vita49_pack_arb.sv
// Packet-granular round-robin arbiter feeding one vita49_pack datapath from NUM_CH
// AXI-Stream sources; holds each grant until TLAST or the latched word limit.
module vita49_pack_arb
  import vita49_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int CH_W   = clog2(NUM_CH)
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      burst_len,
  input  logic [31:0]           stream_id_base,
  input  logic [NUM_CH-1:0]     S_AXIS_TVALID,
  input  logic [32*NUM_CH-1:0]  S_AXIS_TDATA,
  input  logic [NUM_CH-1:0]     S_AXIS_TLAST,
  output logic [NUM_CH-1:0]     S_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  output logic [31:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  grant_valid,
  output logic [CH_W-1:0]       grant_ch,
  output logic [31:0]           stream_id
);

  arb_state_e       state_q, state_d;
  logic [CH_W-1:0]  grant_ch_q, grant_ch_d;
  logic             grant_valid_q, grant_valid_d;
  logic [31:0]      stream_id_q, stream_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;

  logic [CH_W-1:0]  arb_idx;
  logic             arb_any;
  logic             active;
  logic             handshake;
  logic             lim_hit;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .req        (S_AXIS_TVALID),
    .last_grant (last_grant_q),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // Zero-latency pass-through of the granted channel; everything else sees ready=0.
  always_comb begin
    int g;
    g             = int'(grant_ch_q);
    active        = (state_q == ACTIVE);
    lim_hit       = (lim_q != '0) && (cnt_q == lim_q - CNT_W'(1));
    M_AXIS_TDATA  = S_AXIS_TDATA[32*g +: 32];
    M_AXIS_TVALID = active && S_AXIS_TVALID[g];
    M_AXIS_TLAST  = active && (S_AXIS_TLAST[g] || lim_hit);
    S_AXIS_TREADY = '0;
    if (active) S_AXIS_TREADY[g] = M_AXIS_TREADY;
    handshake     = M_AXIS_TVALID && M_AXIS_TREADY;
  end

  always_comb begin
    state_d       = state_q;
    grant_ch_d    = grant_ch_q;
    grant_valid_d = grant_valid_q;
    stream_id_d   = stream_id_q;
    cnt_d         = cnt_q;
    lim_d         = lim_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      IDLE: begin
        if (enable && arb_any) begin
          grant_ch_d    = arb_idx;
          grant_valid_d = 1'b1;
          stream_id_d   = stream_id_base + 32'(arb_idx);
          lim_d         = burst_len;
          cnt_d         = '0;
          state_d       = ACTIVE;
        end
      end
      ACTIVE: begin
        if (handshake) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (M_AXIS_TLAST) begin
            last_grant_d  = grant_ch_q;
            cnt_d         = '0;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to the top channel so channel 0 is scanned first.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q       <= IDLE;
      grant_ch_q    <= '0;
      grant_valid_q <= 1'b0;
      stream_id_q   <= '0;
      cnt_q         <= '0;
      lim_q         <= '0;
      last_grant_q  <= CH_W'(NUM_CH - 1);
    end else begin
      state_q       <= state_d;
      grant_ch_q    <= grant_ch_d;
      grant_valid_q <= grant_valid_d;
      stream_id_q   <= stream_id_d;
      cnt_q         <= cnt_d;
      lim_q         <= lim_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_ch    = grant_ch_q;
  assign stream_id   = stream_id_q;

endmodule
